mem_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 64-bit Memory block on the SOC memory bus. Requester 0 is the CPU instruction-fetch port and requester 1 is the CPU data (load/store) port. The block serialises accesses, drives Memory's address, data and rw lines for a fixed access latency, then returns read data with a completion pulse to the winning requester. It sits between CPU and Memory inside SOC.

---
 rtl/mem_arbiter.sv | 81 ++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter sequencing fixed-latency accesses to a shared memory
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [3:0] cnt;
  logic last;
  logic win;
  always_comb win = (req0 & req1) ? ~last : req1;
  // last doubles as the owner of the transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      last <= 1'b1;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      mem_en <= 1'b0;
      mem_rw <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (state == IDLE) begin
        if (req0 | req1) begin
          state <= BUSY;
          last <= win;
          gnt0 <= ~win;
          gnt1 <= win;
          mem_en <= 1'b1;
          mem_rw <= win ? we1 : we0;
          mem_addr <= win ? addr1 : addr0;
          mem_wdata <= win ? wdata1 : wdata0;
          cnt <= 4'(MEM_LATENCY - 1);
        end
      end else if (cnt == 4'd0) begin
        state <= IDLE;
        mem_en <= 1'b0;
        mem_rw <= 1'b0;
        done0 <= ~last;
        done1 <= last;
        if (!mem_rw && !last) rdata0 <= mem_rdata;
        if (!mem_rw && last) rdata1 <= mem_rdata;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter at latencies 1 and 3
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic req[2][2], we[2][2], gnt[2][2], done[2][2];
  logic [63:0] addr[2][2], wdata[2][2], rdata[2][2];
  logic mem_en[2], mem_rw[2];
  logic [63:0] mem_addr[2], mem_wdata[2], mem_rdata[2];
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0(req[0][0]), .we0(we[0][0]), .addr0(addr[0][0]), .wdata0(wdata[0][0]),
    .gnt0(gnt[0][0]), .done0(done[0][0]), .rdata0(rdata[0][0]),
    .req1(req[0][1]), .we1(we[0][1]), .addr1(addr[0][1]), .wdata1(wdata[0][1]),
    .gnt1(gnt[0][1]), .done1(done[0][1]), .rdata1(rdata[0][1]),
    .mem_en(mem_en[0]), .mem_rw(mem_rw[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0(req[1][0]), .we0(we[1][0]), .addr0(addr[1][0]), .wdata0(wdata[1][0]),
    .gnt0(gnt[1][0]), .done0(done[1][0]), .rdata0(rdata[1][0]),
    .req1(req[1][1]), .we1(we[1][1]), .addr1(addr[1][1]), .wdata1(wdata[1][1]),
    .gnt1(gnt[1][1]), .done1(done[1][1]), .rdata1(rdata[1][1]),
    .mem_en(mem_en[1]), .mem_rw(mem_rw[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

  function automatic int lat(int k);
    return (k != 0) ? 3 : 1;
  endfunction

  // Reference model: each transaction is an accept cycle t; everything else follows from t and the latency
  bit m_act[2], m_w[2], m_we[2], m_last[2];
  int m_t[2];
  logic [63:0] m_addr[2], m_wdata[2], m_rd[2][2];
  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_act[k] = 1'b0;
        m_last[k] = 1'b1;
        m_addr[k] = '0;
        m_wdata[k] = '0;
        m_rd[k][0] = '0;
        m_rd[k][1] = '0;
      end else begin
        if (m_act[k] && cyc == m_t[k] + lat(k) && !m_we[k]) m_rd[k][m_w[k]] = mem_rdata[k];
        if ((!m_act[k] || cyc >= m_t[k] + lat(k) + 1) && (req[k][0] || req[k][1])) begin
          m_w[k] = (req[k][0] && req[k][1]) ? !m_last[k] : req[k][1];
          m_last[k] = m_w[k];
          m_we[k] = we[k][m_w[k]];
          m_addr[k] = addr[k][m_w[k]];
          m_wdata[k] = wdata[k][m_w[k]];
          m_act[k] = 1'b1;
          m_t[k] = cyc;
        end
      end
    end
  end

  function automatic logic [261:0] expv(int k);
    int d = cyc - m_t[k];
    int l = lat(k);
    logic a = m_act[k];
    logic w = m_w[k];
    logic en = a && d >= 1 && d <= l;
    return {a && d == 1 && !w, a && d == 1 && w, a && d == l + 1 && !w, a && d == l + 1 && w,
            en, en && m_we[k], m_addr[k], m_wdata[k], m_rd[k][0], m_rd[k][1]};
  endfunction

  function automatic logic [261:0] obsv(int k);
    return {gnt[k][0], gnt[k][1], done[k][0], done[k][1], mem_en[k], mem_rw[k],
            mem_addr[k], mem_wdata[k], rdata[k][0], rdata[k][1]};
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = '0;
      for (int r = 0; r < 2; r++) begin
        req[k][r] = 1'b0;
        we[k][r] = 1'b0;
        addr[k][r] = '0;
        wdata[k][r] = '0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drive_rand(int k);
    logic [261:0] e = expv(k);
    for (int r = 0; r < 2; r++) begin
      if (!req[k][r] || e[261-r]) begin
        req[k][r] = ($urandom_range(0, 2) != 0);
        we[k][r] = 1'($urandom_range(0, 1));
        addr[k][r] = {$urandom, $urandom};
        wdata[k][r] = {$urandom, $urandom};
      end
    end
    mem_rdata[k] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    clear_inputs();
    req[0][0] = 1'b1;
    req[1][1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obsv(k) !== 262'b0) begin
        errs++;
        $display("FAIL reset lat%0d: got %h want 0", lat(k), obsv(k));
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req[0][0] = 1'b1;
    addr[0][0] = 64'h100;
    @(negedge clk);
    checks++;
    if ({gnt[0][0], gnt[0][1], mem_en[0], mem_rw[0], mem_addr[0]} !== {4'b1010, 64'h100}) begin
      errs++;
      $display("FAIL single_read c1: got %b %b %b %b %h want 1 0 1 0 100", gnt[0][0], gnt[0][1], mem_en[0], mem_rw[0], mem_addr[0]);
    end
    req[0][0] = 1'b0;
    mem_rdata[0] = 64'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({done[0][0], done[0][1], mem_en[0], rdata[0][0], rdata[0][1]} !== {3'b100, 64'hDEADBEEF, 64'h0}) begin
      errs++;
      $display("FAIL single_read c2: got done %b%b en %b rdata0 %h rdata1 %h want 10 0 deadbeef 0", done[0][0], done[0][1], mem_en[0], rdata[0][0], rdata[0][1]);
    end
  endtask

  task automatic test_tie();
    logic [3:0] want[4] = '{4'b1000, 4'b0010, 4'b0100, 4'b0001};
    do_reset();
    req[0][0] = 1'b1;
    req[0][1] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt[0][0], gnt[0][1], done[0][0], done[0][1]} !== want[c-1]) begin
        errs++;
        $display("FAIL tie c%0d: gnt/done got %b want %b", c, {gnt[0][0], gnt[0][1], done[0][0], done[0][1]}, want[c-1]);
      end
      if (gnt[0][0]) req[0][0] = 1'b0;
      if (gnt[0][1]) req[0][1] = 1'b0;
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      req[0][r] = 1'b1;
      addr[0][r] = {$urandom, $urandom};
      we[0][r] = 1'b0;
    end
    for (int c = 1; c <= 12; c++) begin
      mem_rdata[0] = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if ({gnt[0][0], gnt[0][1], done[0][0], done[0][1]} !== {c % 4 == 1, c % 4 == 3, c % 4 == 2, c % 4 == 0}) begin
        errs++;
        $display("FAIL contention c%0d: gnt/done got %b%b%b%b", c, gnt[0][0], gnt[0][1], done[0][0], done[0][1]);
      end
      checks++;
      if (obsv(0) !== expv(0)) begin
        errs++;
        $display("FAIL contention_model c%0d: got %h want %h", c, obsv(0), expv(0));
      end
      for (int r = 0; r < 2; r++) if (gnt[0][r]) addr[0][r] = {$urandom, $urandom};
    end
  endtask

  task automatic test_write_read();
    do_reset();
    req[0][1] = 1'b1;
    we[0][1] = 1'b1;
    addr[0][1] = 64'h8;
    wdata[0][1] = 64'h1234;
    @(negedge clk);
    checks++;
    if ({gnt[0][1], mem_en[0], mem_rw[0], mem_addr[0], mem_wdata[0]} !== {3'b111, 64'h8, 64'h1234}) begin
      errs++;
      $display("FAIL write c1: got gnt1 %b en %b rw %b addr %h wdata %h", gnt[0][1], mem_en[0], mem_rw[0], mem_addr[0], mem_wdata[0]);
    end
    we[0][1] = 1'b0;
    mem_rdata[0] = 64'h7777;
    @(negedge clk);
    checks++;
    if ({done[0][1], rdata[0][1]} !== {1'b1, 64'h0}) begin
      errs++;
      $display("FAIL write_done: got done1 %b rdata1 %h want 1 0", done[0][1], rdata[0][1]);
    end
    @(negedge clk);
    checks++;
    if ({gnt[0][1], mem_en[0], mem_rw[0], mem_addr[0]} !== {3'b110, 64'h8}) begin
      errs++;
      $display("FAIL read c3: got gnt1 %b en %b rw %b addr %h", gnt[0][1], mem_en[0], mem_rw[0], mem_addr[0]);
    end
    req[0][1] = 1'b0;
    mem_rdata[0] = 64'hCAFE;
    @(negedge clk);
    checks++;
    if ({done[0][1], rdata[0][1], rdata[0][0]} !== {1'b1, 64'hCAFE, 64'h0}) begin
      errs++;
      $display("FAIL read_done: got done1 %b rdata1 %h rdata0 %h want 1 cafe 0", done[0][1], rdata[0][1], rdata[0][0]);
    end
  endtask

  task automatic test_latency3();
    do_reset();
    req[1][0] = 1'b1;
    addr[1][0] = 64'h200;
    mem_rdata[1] = 64'h1111;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_en[1], mem_rw[1], mem_addr[1], done[1][0]} !== {2'b10, 64'h200, 1'b0}) begin
        errs++;
        $display("FAIL lat3 c%0d: got en %b rw %b addr %h done0 %b", c, mem_en[1], mem_rw[1], mem_addr[1], done[1][0]);
      end
      req[1][0] = 1'b0;
      if (c == 3) mem_rdata[1] = 64'hABCD;
    end
    @(negedge clk);
    checks++;
    if ({done[1][0], mem_en[1], rdata[1][0]} !== {2'b10, 64'hABCD}) begin
      errs++;
      $display("FAIL lat3_done: got done0 %b en %b rdata0 %h want 1 0 abcd", done[1][0], mem_en[1], rdata[1][0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req[1][0] = 1'b1;
    addr[1][0] = 64'h300;
    mem_rdata[1] = 64'h55;
    @(negedge clk);
    req[1][0] = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_en[1] !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid_pre: mem_en got %b want 1", mem_en[1]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obsv(1) !== 262'b0) begin
      errs++;
      $display("FAIL reset_mid_now: got %h want 0", obsv(1));
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({done[1][0], done[1][1], mem_en[1]} !== 3'b000) begin
        errs++;
        $display("FAIL reset_mid_quiet c%0d: done/en got %b%b%b want 000", c, done[1][0], done[1][1], mem_en[1]);
      end
    end
    req[1][0] = 1'b1;
    req[1][1] = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt[1][0], gnt[1][1]} !== 2'b10) begin
      errs++;
      $display("FAIL reset_mid_tie: gnt got %b%b want 10", gnt[1][0], gnt[1][1]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) drive_rand(k);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          errs++;
          $display("FAIL random lat%0d cyc%0d: got %h want %h", lat(k), cyc, obsv(k), expv(k));
        end
        checks++;
        if ((gnt[k][0] && gnt[k][1]) || (done[k][0] && done[k][1])) begin
          errs++;
          $display("FAIL random_exclusive lat%0d cyc%0d: gnt %b%b done %b%b", lat(k), cyc, gnt[k][0], gnt[k][1], done[k][0], done[k][1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_contention();
    test_write_read();
    test_latency3();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
